spike_rate_decoder: RTL

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

---
 rtl/spike_rate_decoder.sv | 65 ++++++
 1 files changed

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts spikes over back-to-back windows and hands the
// per-window count to a valid/ready consumer, dropping results it cannot hold.
module spike_rate_decoder #(
  parameter int n_stage = 2,
  parameter int win_w = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               is_spike,
  input  logic [win_w-1:0]   window_len,
  output logic [n_stage+1:0] rate,
  output logic               rate_valid,
  input  logic               rate_ready,
  output logic               saturated,
  output logic               dropped
);
  localparam int cw = n_stage + 2;
  typedef enum logic {idle, count} state_t;
  state_t state;
  logic [win_w-1:0] len, cyc, eff_len;
  logic [cw-1:0] spk, sum;
  logic sat, clip, last, done, load, hs;
  always_comb begin
    clip = (spk == '1) && is_spike;
    sum = clip ? spk : spk + cw'(is_spike);
    last = cyc == len - win_w'(1);
    eff_len = (window_len == '0) ? win_w'(1) : window_len;
    done = (state == count) && en && last;
    hs = rate_valid && rate_ready;
    load = done && (!rate_valid || rate_ready);
  end
  // Any window boundary (entry, exit, or last cycle) restarts both counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= idle;
      len <= '0;
      cyc <= '0;
      spk <= '0;
      sat <= 1'b0;
      rate <= '0;
      rate_valid <= 1'b0;
      saturated <= 1'b0;
      dropped <= 1'b0;
    end else begin
      dropped <= done && !load;
      if (load) begin
        rate <= sum;
        saturated <= sat || clip;
        rate_valid <= 1'b1;
      end else if (hs) rate_valid <= 1'b0;
      state <= en ? count : idle;
      if (state == idle || !en || last) begin
        cyc <= '0;
        spk <= '0;
        sat <= 1'b0;
        if (en) len <= eff_len;
      end else begin
        cyc <= cyc + win_w'(1);
        spk <= sum;
        sat <= sat || clip;
      end
    end
  end
endmodule
